// File: rtl/rsa_request_sequencer_pkg.sv
// Shared definitions for the RSA request sequencer: controller state encoding,
// default sizing and the timeout counter width helper.
package rsa_request_sequencer_pkg;

    localparam int DefaultWordSize      = 32;
    localparam int DefaultTimeoutCycles = 4096;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StRun,
        StDone
    } seqState_t;

    // The counter only has to reach TimeoutCycles-1, so clog2 bits suffice.
    function automatic int counterWidth(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/rsa_request_sequencer_if.sv
// Request, response and engine-control bundle of the RSA request sequencer.
// The sequencer uses the slave view; the environment uses the master view.
interface rsa_request_sequencer_if
    import rsa_request_sequencer_pkg::*;
#(
    parameter int WordSize = DefaultWordSize
);

    logic                req_valid;
    logic                req_ready;
    logic [WordSize-1:0] req_text;
    logic [WordSize-1:0] req_key;
    logic [WordSize-1:0] req_mod;

    logic                resp_valid;
    logic                resp_ready;
    logic [WordSize-1:0] resp_data;
    logic                resp_err;

    logic [WordSize-1:0] eng_text;
    logic [WordSize-1:0] eng_key;
    logic [WordSize-1:0] eng_mod;
    logic                eng_load;
    logic                eng_running;
    logic                eng_divide;
    logic                eng_over;
    logic [WordSize-1:0] eng_result;

    modport slave (
        input  req_valid, req_text, req_key, req_mod, resp_ready, eng_over, eng_result,
        output req_ready, resp_valid, resp_data, resp_err,
               eng_text, eng_key, eng_mod, eng_load, eng_running, eng_divide
    );

    modport master (
        output req_valid, req_text, req_key, req_mod, resp_ready, eng_over, eng_result,
        input  req_ready, resp_valid, resp_data, resp_err,
               eng_text, eng_key, eng_mod, eng_load, eng_running, eng_divide
    );

endinterface

// File: rtl/rsa_request_sequencer_cycle_counter.sv
// Free-running RUN-cycle counter with synchronous clear, used to bound
// how long the sequencer waits for the exponentiation engine.
module cycle_counter #(
    parameter int Width = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [Width-1:0] o_count
);

    logic [Width-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/rsa_request_sequencer.sv
// Sequences one modular-exponentiation request at a time through the external
// engine: clear, load, run with timeout, then hold the response until consumed.
module rsa_request_sequencer
    import rsa_request_sequencer_pkg::*;
#(
    parameter int WordSize      = DefaultWordSize,
    parameter int TimeoutCycles = DefaultTimeoutCycles
) (
    input logic                    clk,
    input logic                    reset,
    rsa_request_sequencer_if.slave bus
);

    localparam int                    CountWidth = counterWidth(TimeoutCycles);
    localparam logic [CountWidth-1:0] LastCount  = CountWidth'(TimeoutCycles - 1);
    localparam logic [WordSize-1:0]   MinModulus = WordSize'(2);

    seqState_t           r_state;
    logic [WordSize-1:0] r_text;
    logic [WordSize-1:0] r_key;
    logic [WordSize-1:0] r_mod;
    logic [WordSize-1:0] r_respData;
    logic                r_respErr;
    logic                r_respValid;
    logic                r_reqReady;
    logic                r_engDivide;
    logic                r_engLoad;
    logic                r_engRunning;

    logic [CountWidth-1:0] w_count;
    logic                  w_inRun;
    logic                  w_overSeen;
    logic                  w_timeout;

    assign w_inRun    = (r_state == StRun);
    // A count of zero marks the first RUN cycle, where a leftover finish flag is ignored.
    assign w_overSeen = bus.eng_over && (w_count != '0);
    assign w_timeout  = (w_count == LastCount);

    cycle_counter #(
        .Width(CountWidth)
    ) u_runCounter (
        .clk     (clk),
        .reset   (reset),
        .i_clear (!w_inRun),
        .i_enable(w_inRun),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_text       <= '0;
            r_key        <= '0;
            r_mod        <= '0;
            r_respData   <= '0;
            r_respErr    <= 1'b0;
            r_respValid  <= 1'b0;
            r_reqReady   <= 1'b1;
            r_engDivide  <= 1'b1;
            r_engLoad    <= 1'b0;
            r_engRunning <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        r_text     <= bus.req_text;
                        r_key      <= bus.req_key;
                        r_mod      <= bus.req_mod;
                        r_reqReady <= 1'b0;
                        if (bus.req_mod < MinModulus) begin
                            r_state     <= StDone;
                            r_respData  <= '0;
                            r_respErr   <= 1'b1;
                            r_respValid <= 1'b1;
                        end else begin
                            r_state   <= StClear;
                            r_engLoad <= 1'b1;
                        end
                    end
                end
                StClear: begin
                    r_state     <= StLoad;
                    r_engDivide <= 1'b0;
                end
                StLoad: begin
                    r_state      <= StRun;
                    r_engRunning <= 1'b1;
                end
                StRun: begin
                    // A finish flag on the timeout cycle still delivers the result.
                    if (w_overSeen || w_timeout) begin
                        r_state      <= StDone;
                        r_respData   <= w_overSeen ? bus.eng_result : '0;
                        r_respErr    <= !w_overSeen;
                        r_respValid  <= 1'b1;
                        r_engDivide  <= 1'b1;
                        r_engLoad    <= 1'b0;
                        r_engRunning <= 1'b0;
                    end
                end
                StDone: begin
                    if (bus.resp_ready) begin
                        r_state     <= StIdle;
                        r_text      <= '0;
                        r_key       <= '0;
                        r_mod       <= '0;
                        r_respData  <= '0;
                        r_respErr   <= 1'b0;
                        r_respValid <= 1'b0;
                        r_reqReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_reqReady;
    assign bus.resp_valid  = r_respValid;
    assign bus.resp_data   = r_respData;
    assign bus.resp_err    = r_respErr;
    assign bus.eng_text    = r_text;
    assign bus.eng_key     = r_key;
    assign bus.eng_mod     = r_mod;
    assign bus.eng_load    = r_engLoad;
    assign bus.eng_running = r_engRunning;
    assign bus.eng_divide  = r_engDivide;

endmodule
